// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants and types for the PDM decimator.
package pdm_pkg;
    localparam int PDM_WORD_LENGTH = 16;
    localparam int POPCOUNT_WIDTH  = 5;
    typedef logic [POPCOUNT_WIDTH-1:0] popcount_t;
    typedef enum logic {FILL, RUN} decim_state_t;
endpackage

// File: rtl/pdm_popcount.sv
// pdm_popcount: combinational ones-count of one PDM word.
module pdm_popcount
    import pdm_pkg::*;
(
    input  logic [PDM_WORD_LENGTH-1:0] i_word,
    output popcount_t                  o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < PDM_WORD_LENGTH; i++) o_count = o_count + popcount_t'(i_word[i]);
    end
endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM word popcount + boxcar moving sum -> signed PCM on valid/ready.
// Define PDM_OVERRUN_COUNT_EN to build the saturating dropped-sample counter.
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int WORD_LENGTH  = 16,
    parameter int WINDOW_WORDS = 8,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic                    enable_i,
    input  logic                    word_done_i,
    input  logic [WORD_LENGTH-1:0]  word_i,
    output logic [SAMPLE_WIDTH-1:0] sample_o,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    output logic [7:0]              overrun_count_o
);
    localparam int SUM_W = $clog2(16*WINDOW_WORDS) + 1;
    localparam int PTR_W = $clog2(WINDOW_WORDS);
    localparam int SHIFT = SAMPLE_WIDTH - 1 - $clog2(16*WINDOW_WORDS);

    logic                    r_done_d;
    logic [WORD_LENGTH-1:0]  r_word;
    logic                    r_v1;
    popcount_t               r_pc;
    logic                    r_v2;
    popcount_t               r_ring [WINDOW_WORDS];
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_fill;
    logic [SUM_W-1:0]        r_sum;
    logic                    r_v3;
    decim_state_t            r_state;
    decim_state_t            w_state_nxt;
    popcount_t               w_pc;
    logic                    w_edge;
    logic                    w_last;
    logic                    w_emit;
    logic [SAMPLE_WIDTH-1:0] w_sample;

    pdm_popcount u_popcount (
        .i_word  (r_word),
        .o_count (w_pc)
    );

    assign w_edge   = word_done_i & ~r_done_d;
    assign w_last   = r_fill == PTR_W'(WINDOW_WORDS - 1);
    // Centre on half density, then scale the window range onto the sample width.
    assign w_sample = (SAMPLE_WIDTH'(r_sum) - SAMPLE_WIDTH'(8*WINDOW_WORDS)) << SHIFT;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) r_done_d <= 1'b0;
        else            r_done_d <= word_done_i;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_word <= '0;
            r_v1   <= 1'b0;
            r_pc   <= '0;
            r_v2   <= 1'b0;
            r_sum  <= '0;
            r_ptr  <= '0;
            r_fill <= '0;
            r_v3   <= 1'b0;
            for (int i = 0; i < WINDOW_WORDS; i++) r_ring[i] <= '0;
        end else if (!enable_i) begin
            r_word <= '0;
            r_v1   <= 1'b0;
            r_pc   <= '0;
            r_v2   <= 1'b0;
            r_sum  <= '0;
            r_ptr  <= '0;
            r_fill <= '0;
            r_v3   <= 1'b0;
            for (int i = 0; i < WINDOW_WORDS; i++) r_ring[i] <= '0;
        end else begin
            r_v1 <= w_edge;
            if (w_edge) r_word <= word_i;
            r_v2 <= r_v1;
            if (r_v1) r_pc <= w_pc;
            r_v3 <= w_emit;
            if (r_v2) begin
                r_sum         <= r_sum + SUM_W'(r_pc) - SUM_W'(r_ring[r_ptr]);
                r_ring[r_ptr] <= r_pc;
                r_ptr         <= r_ptr + PTR_W'(1);
                if (r_state == FILL) r_fill <= r_fill + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)     r_state <= FILL;
        else if (!enable_i) r_state <= FILL;
        else                r_state <= w_state_nxt;
    end

    always_comb w_state_nxt = (r_state == FILL && r_v2 && w_last) ? RUN : r_state;

    // The update that completes the window already emits.
    always_comb w_emit = r_v2 && (r_state == RUN || w_last);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
        end else if (!enable_i) begin
            sample_valid_o <= 1'b0;
        end else if (r_v3 && (!sample_valid_o || sample_ready_i)) begin
            sample_o       <= w_sample;
            sample_valid_o <= 1'b1;
        end else if (sample_ready_i) begin
            sample_valid_o <= 1'b0;
        end
    end

`ifdef PDM_OVERRUN_COUNT_EN
    logic [7:0] r_ovr;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) r_ovr <= 8'd0;
        else if (enable_i && r_v3 && sample_valid_o && !sample_ready_i && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
    end
    assign overrun_count_o = r_ovr;
`else
    assign overrun_count_o = 8'd0;
`endif
endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: random and directed stimulus against a window-history reference model.
module tb_pdm_decimator;
    localparam int W     = 8;
    localparam int SHIFT = 8;
`ifdef PDM_OVERRUN_COUNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    typedef struct {int due; int val;} arr_t;

    logic        clock_i        = 1'b0;
    logic        reset_n_i      = 1'b0;
    logic        enable_i       = 1'b0;
    logic        word_done_i    = 1'b0;
    logic [15:0] word_i         = 16'h0;
    logic        sample_ready_i = 1'b0;
    logic [15:0] sample_o;
    logic        sample_valid_o;
    logic [7:0]  overrun_count_o;

    pdm_decimator dut (
        .clock_i         (clock_i),
        .reset_n_i       (reset_n_i),
        .enable_i        (enable_i),
        .word_done_i     (word_done_i),
        .word_i          (word_i),
        .sample_o        (sample_o),
        .sample_valid_o  (sample_valid_o),
        .sample_ready_i  (sample_ready_i),
        .overrun_count_o (overrun_count_o)
    );

    always #5 clock_i = ~clock_i;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got_v, input int exp_v);
        n_chk++;
        if (got_v == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got_v, exp_v, $time);
    endtask

    // Reference model: interface-level behaviour from the window history.
    bit   m_valid = 1'b0;
    int   m_sample = 0;
    int   m_ovr = 0;
    bit   prev_done = 1'b0;
    int   cyc = 0;
    int   hist[$];
    arr_t arrq[$];
    int   got[$];

    always @(negedge clock_i) begin
        int v;
        int s;
        bit arrive;
        cyc++;
        if (!reset_n_i) begin
            check("rst_sample", int'(sample_o), 0);
            check("rst_valid", int'(sample_valid_o), 0);
            check("rst_overrun", int'(overrun_count_o), 0);
            m_valid = 1'b0;
            m_sample = 0;
            m_ovr = 0;
            prev_done = 1'b0;
            hist.delete();
            arrq.delete();
        end else begin
            check("valid", int'(sample_valid_o), int'(m_valid));
            if (m_valid) check("sample", int'($signed(sample_o)), m_sample);
            check("overrun", int'(overrun_count_o), OVR_EN ? m_ovr : 0);
            if (sample_valid_o && sample_ready_i) got.push_back(int'($signed(sample_o)));
            if (!enable_i) begin
                m_valid = 1'b0;
                hist.delete();
                arrq.delete();
            end else begin
                arrive = 1'b0;
                v = 0;
                if (arrq.size() > 0 && arrq[0].due == cyc) begin
                    arrive = 1'b1;
                    v = arrq[0].val;
                    void'(arrq.pop_front());
                end
                if (arrive && (!m_valid || sample_ready_i)) begin
                    m_valid = 1'b1;
                    m_sample = v;
                end else if (arrive) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                else if (sample_ready_i) m_valid = 1'b0;
                if (word_done_i && !prev_done) begin
                    hist.push_back($countones(word_i));
                    if (hist.size() > W) void'(hist.pop_front());
                    if (hist.size() == W) begin
                        s = 0;
                        foreach (hist[i]) s += hist[i];
                        arrq.push_back(arr_t'{due: cyc + 3, val: (s - 8*W) * (1 << SHIFT)});
                    end
                end
            end
            prev_done = word_done_i;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] w, input int hold, input int gap);
        word_i = w;
        word_done_i = 1'b1;
        tick(hold);
        word_done_i = 1'b0;
        tick(gap);
    endtask

    initial begin
        tick(3);
        check("reset_valid", int'(sample_valid_o), 0);
        check("reset_sample", int'(sample_o), 0);
        reset_n_i = 1'b1;
        enable_i = 1'b1;
        sample_ready_i = 1'b1;
        tick(2);

        for (int i = 0; i < 7; i++) send(16'hFFFF, 1, 1);
        word_i = 16'hFFFF;
        word_done_i = 1'b1;
        tick(1);
        word_done_i = 1'b0;
        tick(2);
        check("latency_n2_valid", int'(sample_valid_o), 0);
        tick(1);
        check("latency_n3_valid", int'(sample_valid_o), 1);
        check("full_ones", int'($signed(sample_o)), 16384);
        tick(4);
        check("fill_count", got.size(), 1);
        got.delete();

        for (int i = 0; i < 8; i++) send(16'h0000, 1, 1);
        tick(5);
        check("ramp_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check("ramp_value", got[i], 12288 - 4096*i);

        enable_i = 1'b0;
        tick(2);
        enable_i = 1'b1;
        got.delete();
        for (int i = 0; i < 12; i++) send((i % 2) ? 16'h5555 : 16'hAAAA, 1, 2);
        tick(5);
        check("half_count", got.size(), 5);
        for (int i = 0; i < 5; i++) check("half_value", got[i], 0);

        enable_i = 1'b0;
        tick(1);
        enable_i = 1'b1;
        got.delete();
        for (int i = 0; i < 7; i++) send(16'hFFFF, 1, 1);
        send(16'hFFFF, 10, 1);
        tick(5);
        check("held_done_count", got.size(), 1);
        check("held_done_value", got[0], 16384);

        got.delete();
        sample_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(16'h0000, 1, 1);
        tick(4);
        check("ovr_valid", int'(sample_valid_o), 1);
        check("ovr_held_sample", int'($signed(sample_o)), 12288);
        check("ovr_count", int'(overrun_count_o), OVR_EN ? 2 : 0);
        sample_ready_i = 1'b1;
        tick(1);
        check("ovr_drain_valid", int'(sample_valid_o), 0);
        check("ovr_drain_count", got.size(), 1);
        check("ovr_drain_value", got[0], 12288);

        sample_ready_i = 1'b0;
        send(16'hFFFF, 1, 1);
        tick(3);
        check("pre_rst_sample", int'($signed(sample_o)), 4096);
        word_i = 16'hFFFF;
        word_done_i = 1'b1;
        tick(1);
        word_done_i = 1'b0;
        tick(1);
        reset_n_i = 1'b0;
        #1;
        check("async_rst_sample", int'(sample_o), 0);
        check("async_rst_valid", int'(sample_valid_o), 0);
        check("async_rst_overrun", int'(overrun_count_o), 0);
        tick(2);
        reset_n_i = 1'b1;
        sample_ready_i = 1'b1;
        got.delete();
        for (int i = 0; i < 7; i++) send(16'hFFFF, 1, 1);
        tick(5);
        check("refill_none", got.size(), 0);
        send(16'hFFFF, 1, 1);
        tick(5);
        check("refill_count", got.size(), 1);
        check("refill_value", got[0], 16384);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                enable_i = 1'b0;
                tick(int'($urandom_range(1, 3)));
                enable_i = 1'b1;
            end
            sample_ready_i = ($urandom_range(0, 4) != 0);
            send(16'($urandom()), int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        end

        sample_ready_i = 1'b1;
        tick(5);
        sample_ready_i = 1'b0;
        for (int i = 0; i < 260; i++) send(16'($urandom()), 1, 1);
        tick(5);
        check("ovr_saturate", int'(overrun_count_o), OVR_EN ? 255 : 0);
        sample_ready_i = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Downstream stage of the PDM deserializer: consumes each 16-bit PDM word when the deserializer raises its done flag, and converts bit density to a signed PCM sample.
- Converts via per-word popcount plus a moving-sum (boxcar) filter over the last WINDOW_WORDS words.
- Emits one PCM sample per accepted word on a valid/ready interface toward the controller and audio buffer.

Parameters:
- WORD_LENGTH, 16, width of incoming PDM word; must be 16 (popcount range 0..16).
- WINDOW_WORDS, 8, boxcar window length in words; power of 2, range 2..64.
- SAMPLE_WIDTH, 16, width of signed PCM output.

Ports:
- clock_i  in  1  100 MHz system clock
- reset_n_i  in  1  asynchronous active-low reset
- enable_i  in  1  block enable from controller; low = synchronous flush
- word_done_i  in  1  deserializer done flag (level; may stay high several cycles)
- word_i  in  WORD_LENGTH  deserializer data word, stable while word_done_i high
- sample_o  out  SAMPLE_WIDTH  signed PCM sample
- sample_valid_o  out  1  sample_o holds an unconsumed sample
- sample_ready_i  in  1  consumer accepts sample this cycle
- overrun_count_o  out  8  saturating count of dropped samples

Behaviour:
- Reset (reset_n_i low, async): sample_o=0, sample_valid_o=0, overrun_count_o=0; sum, ring buffer, fill counter, pipeline valids and done-edge register cleared.
- Word capture: a word is taken only on a rising edge of word_done_i (registered previous value low, current high); a held-high level captures once.
- Pipeline, cycle N = edge detected:
  - N: word registered.
  - N+1: popcount registered (5 bits, 0..16).
  - N+2: sum <= sum + pc_new - ring[wr_ptr]; ring[wr_ptr] <= pc_new; wr_ptr wraps modulo WINDOW_WORDS.
- Sum width: clog2(16*WINDOW_WORDS)+1 bits, unsigned; never overflows.
- State machine:
  - FILL: fill counter counts words 0..WINDOW_WORDS-1; no samples emitted.
  - FILL -> RUN: on the WINDOW_WORDS-th sum update.
  - RUN: every sum update produces a sample, including the transition update.
- Sample value: (sum - 8*WINDOW_WORDS) << (SAMPLE_WIDTH-1-clog2(16*WINDOW_WORDS)), signed.
  - Defaults: all-ones window -> +16384; all-zeros -> -16384; half density -> 0.
- Output: sample registered at N+3, so first-sample latency after edge = 3 cycles.
  - sample_valid_o stays high until a cycle with sample_ready_i high.
- Simultaneous handshake: new sample arriving while sample_valid_o && sample_ready_i is loaded; valid stays high; no overrun.
- Overrun: new sample arriving while sample_valid_o && !sample_ready_i is dropped; sample_o unchanged; overrun_count_o increments, saturating at 255.
- enable_i low: synchronous clear of pipeline, sum, ring, fill counter, sample_valid_o, and state (-> FILL). overrun_count_o is retained; only reset clears it.
- Back-to-back words: pipeline accepts one word per cycle, but edges are at least 2 cycles apart by construction.

Optional Feature:
- PDM_OVERRUN_COUNT_EN
  - Defined: overrun counter as specified.
  - Undefined: counter logic removed; overrun_count_o tied to 0; drop behaviour unchanged.

Decomposition:
- Package pdm_pkg holds:
  - constants PDM_WORD_LENGTH=16 and POPCOUNT_WIDTH=5;
  - typedef popcount_t;
  - enum decim_state_t {FILL, RUN}.
- One natural sub-module: pdm_popcount (combinational 16-bit popcount, registered in the parent).

Test Plan:
- Reset then 8 words of 16'hFFFF on rising word_done_i edges, ready=1 -> exactly one sample, +16384, valid 3 cycles after the 8th edge.
- Continue with 16'h0000 words -> samples +12288, +8192, ... down to -16384 after 8 words.
- Fill window with alternating 16'hAAAA/16'h5555 -> every sample 0.
- Hold word_done_i high for 10 cycles -> single capture; fill counter advances by 1.
- In RUN, ready=0 with 3 more words -> first sample held; overrun_count_o=2. Then ready=1 -> held sample consumed, valid drops.
- Assert reset_n_i low mid-pipeline (cycle N+1) -> outputs 0 immediately; after release, 8 new words are needed before the first sample.
